// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_pkg: scan-decoder state encoding, hex glyph table and decode helpers
package seg_scan_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, ACCEPT, HOLD} state_e;

    // Active-high {g,f,e,d,c,b,a} glyphs; the entry index is the nibble value
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic void seg_to_hex(input logic [6:0] seg, output logic [3:0] nib, output logic ok);
        nib = 4'h0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++)
            if (GLYPHS[i] == seg) begin
                nib = 4'(i);
                ok  = 1'b1;
            end
    endfunction

    function automatic void onehot0_index(input logic [7:0] an_n, output logic single, output logic [2:0] idx);
        single = ($countones(~an_n) == 1);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++)
            if (!an_n[i]) idx = 3'(i);
    endfunction

endpackage

// File: rtl/seg_digit_timeout.sv
// seg_digit_timeout: per-digit refresh timer; expired is high while the saturated count sits at the limit
module seg_digit_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = accept ? '0 : (cnt_q == LIMIT) ? LIMIT : cnt_q + W'(1);
        expired = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 8-digit seven-segment scan and rebuilds the displayed hex digits
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  anodes,
    input  logic [7:0]  cathodes,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp,
    output logic [7:0]  decode_err,
    output logic        frame_done
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE = SW'(STABLE_CYCLES);

    logic [7:0]    an_meta_q, an_sync_q, ca_meta_q, ca_sync_q;
    state_e        state_q, state_d;
    logic [7:0]    cand_an_q, cand_an_d, cand_ca_q, cand_ca_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [31:0]   digits_q, digits_d;
    logic [7:0]    valid_q, valid_d, dp_q, dp_d, err_q, err_d, seen_q, seen_d;
    logic          frame_q, frame_d;
    logic          single, same, accept, ok;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic [7:0]    acc_vec, expired;

    always_comb begin
        onehot0_index(an_sync_q, single, idx);
        seg_to_hex(~ca_sync_q[6:0], nib, ok);
        same      = (an_sync_q == cand_an_q) && (ca_sync_q == cand_ca_q);
        state_d   = state_q;
        cand_an_d = cand_an_q;
        cand_ca_d = cand_ca_q;
        stab_d    = stab_q;
        if (state_q == ACCEPT)
            state_d = HOLD;
        else if (state_q != IDLE && same) begin
            stab_d  = (state_q == TRACK) ? stab_q + SW'(1) : stab_q;
            state_d = (state_q == TRACK && stab_d == STABLE) ? ACCEPT : state_q;
        end else if (single) begin
            cand_an_d = an_sync_q;
            cand_ca_d = ca_sync_q;
            stab_d    = SW'(1);
            state_d   = (STABLE_CYCLES == 1) ? ACCEPT : TRACK;
        end else
            state_d = IDLE;
    end

    // The accepting sample always equals the candidate, so decode straight from the synchronized lines
    always_comb begin
        accept   = (state_d == ACCEPT);
        acc_vec  = accept ? (8'd1 << idx) : 8'd0;
        digits_d = digits_q;
        dp_d     = dp_q;
        err_d    = err_q;
        if (accept) begin
            digits_d[{idx, 2'b00} +: 4] = nib;
            dp_d[idx]  = ~ca_sync_q[7];
            err_d[idx] = ~ok;
        end
        valid_d = acc_vec | (valid_q & ~expired);
        frame_d = ((seen_q | acc_vec) == 8'hFF);
        seen_d  = frame_d ? 8'h00 : seen_q | acc_vec;
    end

    for (genvar g = 0; g < 8; g++) begin : g_to
        seg_digit_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (acc_vec[g]),
            .expired(expired[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            an_meta_q <= 8'hFF;
            an_sync_q <= 8'hFF;
            ca_meta_q <= 8'hFF;
            ca_sync_q <= 8'hFF;
            state_q   <= IDLE;
            cand_an_q <= 8'h00;
            cand_ca_q <= 8'h00;
            stab_q    <= '0;
            digits_q  <= 32'h0;
            valid_q   <= 8'h00;
            dp_q      <= 8'h00;
            err_q     <= 8'h00;
            seen_q    <= 8'h00;
            frame_q   <= 1'b0;
        end else begin
            an_meta_q <= anodes;
            an_sync_q <= an_meta_q;
            ca_meta_q <= cathodes;
            ca_sync_q <= ca_meta_q;
            state_q   <= state_d;
            cand_an_q <= cand_an_d;
            cand_ca_q <= cand_ca_d;
            stab_q    <= stab_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
        end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign dp          = dp_q;
    assign decode_err  = err_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed test-plan scenarios plus random scans checked against a run-length display model
module tb_seg_scan_decoder;
    localparam int STABLE = 4;
    localparam int TMO    = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  anodes, cathodes;
    logic [31:0] digits;
    logic [7:0]  digit_valid, dp, decode_err;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: two-stage input delay, run length of the current single-digit sample, per-digit display state
    logic [7:0] p_an [2];
    logic [7:0] p_ca [2];
    logic [7:0] prev_an, prev_ca, m_dp, m_err, seen;
    logic [3:0] m_dig [8];
    int         age [8];
    int         run;
    logic       m_frame;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .digits     (digits),
        .digit_valid(digit_valid),
        .dp         (dp),
        .decode_err (decode_err),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        p_an = '{8'hFF, 8'hFF};
        p_ca = '{8'hFF, 8'hFF};
        prev_an = 8'hFF;
        prev_ca = 8'hFF;
        m_dp = 8'h00;
        m_err = 8'h00;
        seen = 8'h00;
        run = 0;
        m_frame = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_dig[i] = 4'h0;
            age[i] = TMO;
        end
    endtask

    task automatic model_edge();
        logic [7:0] an, ca;
        int z, d, k;
        bit hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        an = p_an[1];
        ca = p_ca[1];
        z = 0;
        d = 0;
        for (int i = 0; i < 8; i++)
            if (!an[i]) begin
                z++;
                d = i;
            end
        m_frame = 1'b0;
        for (int i = 0; i < 8; i++)
            if (age[i] < TMO) age[i]++;
        run = (z != 1) ? 0 : (an == prev_an && ca == prev_ca && run > 0) ? run + 1 : 1;
        prev_an = an;
        prev_ca = ca;
        if (run == STABLE) begin
            hit = 0;
            k = 0;
            for (int g = 0; g < 16; g++)
                if (glyph[g] == ~ca[6:0]) begin
                    hit = 1;
                    k = g;
                end
            m_dig[d] = hit ? 4'(k) : 4'h0;
            m_err[d] = !hit;
            m_dp[d]  = !ca[7];
            age[d]   = 0;
            seen[d]  = 1'b1;
            if (seen == 8'hFF) begin
                m_frame = 1'b1;
                seen = 8'h00;
            end
        end
        p_an[1] = p_an[0];
        p_ca[1] = p_ca[0];
        p_an[0] = anodes;
        p_ca[0] = cathodes;
    endtask

    task automatic compare_all();
        logic [31:0] ed;
        logic [7:0]  ev;
        for (int i = 0; i < 8; i++) begin
            ed[4*i +: 4] = m_dig[i];
            ev[i] = (age[i] < TMO);
        end
        check("digits", digits, ed);
        check("valid", 32'(digit_valid), 32'(ev));
        check("dp", 32'(dp), 32'(m_dp));
        check("decode_err", 32'(decode_err), 32'(m_err));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        if (frame_done) frames++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic hold(input logic [7:0] an, input logic [7:0] ca, input int n);
        anodes = an;
        cathodes = ca;
        cyc(n);
    endtask

    initial begin
        logic [7:0] an, ca;
        int len;
        model_reset();
        rst_n = 1'b1;
        anodes = 8'hFF;
        cathodes = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        check("reset_digits", digits, 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        cyc(2);
        rst_n = 1'b1;

        // first accept lands exactly STABLE cycles after the synchronized value appears
        hold(8'hFE, 8'hC0, 5);
        check("t1_not_yet", 32'(digit_valid), 32'h00);
        cyc(1);
        check("t1_nib", 32'(digits[3:0]), 32'h0);
        check("t1_valid", 32'(digit_valid), 32'h01);
        check("t1_dp", 32'(dp[0]), 32'h0);
        check("t1_err", 32'(decode_err), 32'h00);

        frames = 0;
        for (int i = 0; i < 8; i++) begin
            hold(~(8'd1 << i), {1'b1, ~glyph[i + 1]}, 10);
            hold(8'hFF, 8'hFF, 2);
        end
        check("scan_digits", digits, 32'h87654321);
        check("scan_frames", 32'(frames), 32'd1);

        hold(8'hF7, 8'h88, 3);
        hold(8'hFF, 8'hFF, 10);
        check("short_digit3", 32'(digits[15:12]), 32'h4);
        check("short_valid3", 32'(digit_valid[3]), 32'h0);

        hold(8'hFC, 8'hF9, 20);
        check("multi_low_digits", digits, 32'h87654321);
        hold(8'hFB, 8'h7F, 10);
        check("bad_dp2", 32'(dp[2]), 32'h1);
        check("bad_err2", 32'(decode_err[2]), 32'h1);

        hold(8'hDF, 8'h8E, 10);
        check("to_valid5", 32'(digit_valid[5]), 32'h1);
        hold(8'hFF, 8'hFF, 60);
        check("to_cleared5", 32'(digit_valid[5]), 32'h0);
        check("to_hold_nib5", 32'(digits[23:20]), 32'hF);
        hold(8'hDF, 8'h8E, 8);
        check("to_restored5", 32'(digit_valid[5]), 32'h1);
        hold(8'hFF, 8'hFF, 3);

        hold(8'hFD, 8'hF9, 4);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("mid_reset_digits", digits, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(STABLE + 1);
        check("post_reset_wait", 32'(digit_valid[1]), 32'h0);
        cyc(1);
        check("post_reset_acc", 32'(digit_valid[1]), 32'h1);
        check("post_reset_nib", 32'(digits[7:4]), 32'h1);

        for (int s = 0; s < 150; s++) begin
            do begin
                case ($urandom_range(0, 9))
                    0, 1:    an = 8'hFF;
                    2:       an = 8'($urandom);
                    default: an = ~(8'd1 << $urandom_range(0, 7));
                endcase
                ca = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                                 : {1'($urandom), ~glyph[$urandom_range(0, 15)]};
            end while (an == anodes && ca == cathodes);
            len = $urandom_range(1, 9);
            if (len == STABLE) len++;
            hold(an, ca, len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
